load_store_unit: RTL and testbench

//  Memory-stage load/store unit directly downstream of the ALU. Takes ALUResult as the

---
 rtl/load_store_unit.sv | 116 +++++++++++
 tb/tb_load_store_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage byte/half/word load/store over a req/ack RAM handshake with misalign and timeout detection
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    output logic        Stall,
    output logic [31:0] ReadData,
    output logic        LoadValid,
    output logic        AddrErr,
    output logic        BusErr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [1:0]    size_q, off_q;
    logic          sign_q;
    logic          req, aligned, legal, illegal, busy, ack, tmo;
    logic [3:0]    be;
    logic [31:0]   wd, ld;
    logic [7:0]    ld_b;
    logic [15:0]   ld_h;

    assign req     = MemRead | MemWrite;
    assign aligned = (MemSize == 2'b00) | (MemSize == 2'b01 & ~ALUResult[0])
                   | (MemSize == 2'b10 & ALUResult[1:0] == 2'b00);
    assign legal   = req & ~(MemRead & MemWrite) & aligned;
    assign illegal = req & ~legal;
    assign busy    = state == BUSY;
    assign ack     = busy & mem_ack;
    assign tmo     = busy & ~mem_ack & (cnt == CW'(TIMEOUT - 1));
    assign Stall   = busy | legal;

    assign be = MemSize == 2'b00 ? 4'b0001 << ALUResult[1:0]
              : MemSize == 2'b01 ? (ALUResult[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wd = MemSize == 2'b00 ? {4{WriteData[7:0]}}
              : MemSize == 2'b01 ? {2{WriteData[15:0]}} : WriteData;

    assign ld_b = mem_rdata[{off_q, 3'b000} +: 8];
    assign ld_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign ld   = size_q == 2'b00 ? {{24{sign_q & ld_b[7]}}, ld_b}
                : size_q == 2'b01 ? {{16{sign_q & ld_h[15]}}, ld_h} : mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        state_nx = !busy ? (legal ? BUSY : IDLE) : ack ? DONE : tmo ? IDLE : BUSY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            size_q    <= '0;
            off_q     <= '0;
            sign_q    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            ReadData  <= '0;
            LoadValid <= 1'b0;
            AddrErr   <= 1'b0;
            BusErr    <= 1'b0;
        end else begin
            LoadValid <= 1'b0;
            AddrErr   <= 1'b0;
            BusErr    <= 1'b0;
            if (!busy) begin
                AddrErr <= illegal;
                if (legal) begin
                    mem_req   <= 1'b1;
                    mem_we    <= MemWrite;
                    mem_addr  <= {ALUResult[31:2], 2'b00};
                    mem_be    <= be;
                    mem_wdata <= wd;
                    size_q    <= MemSize;
                    sign_q    <= MemSigned;
                    off_q     <= ALUResult[1:0];
                    cnt       <= '0;
                end
            end else if (mem_ack) begin
                mem_req <= 1'b0;
                if (!mem_we) begin
                    ReadData  <= ld;
                    LoadValid <= 1'b1;
                end
            end else if (tmo) begin
                mem_req <= 1'b0;
                BusErr  <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit with directed accesses
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ALUResult, WriteData, mem_rdata;
    logic        MemRead, MemWrite, MemSigned, mem_ack;
    logic [1:0]  MemSize;
    logic        Stall, LoadValid, AddrErr, BusErr, mem_req, mem_we;
    logic [31:0] ReadData, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          kind;
        logic [68:0] val;
        string       nm;
    } exp_t;
    exp_t q[$];

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .ALUResult(ALUResult), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize), .MemSigned(MemSigned),
        .Stall(Stall), .ReadData(ReadData), .LoadValid(LoadValid), .AddrErr(AddrErr),
        .BusErr(BusErr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [68:0] act, input logic [68:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [68:0] v, input string nm);
        exp_t e;
        e.kind = k;
        e.val  = v;
        e.nm   = nm;
        q.push_back(e);
    endtask

    task automatic exp_req(input logic we, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd, input string nm);
        push(0, {we, a, be, wd}, {nm, " req"});
    endtask

    task automatic pop(input int k, input logic [68:0] v);
        exp_t e;
        if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_event: got kind %0d value %h expected none", k, v);
        end else begin
            e = q.pop_front();
            check({e.nm, " kind"}, 69'(k), 69'(e.kind));
            check(e.nm, v, e.val);
        end
    endtask

    // Monitor: kind 0 = new RAM request, 1 = load data, 2 = address error, 3 = bus error
    initial begin
        logic prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_req && !prev_req) pop(0, {mem_we, mem_addr, mem_be, mem_wdata});
                if (LoadValid) pop(1, {37'b0, ReadData});
                if (AddrErr) pop(2, '0);
                if (BusErr) pop(3, {37'b0, ReadData});
            end
            prev_req = mem_req;
        end
    end

    task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                          input int delay, input int exp_stall, input int exp_bc, input string nm);
        int stalls;
        int bc;
        MemRead = rd; MemWrite = wr; MemSize = sz; MemSigned = sg;
        ALUResult = addr; WriteData = wd;
        #1 stalls = int'(Stall);
        bc = 0;
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0;
        for (int k = 0; k < 40 && mem_req; k++) begin
            mem_ack = (bc == delay);
            mem_rdata = rdata;
            #1 if (Stall) stalls++;
            bc++;
            @(negedge clk);
            mem_ack = 1'b0;
        end
        check({nm, " stall_cycles"}, 69'(stalls), 69'(exp_stall));
        check({nm, " req_cycles"}, 69'(bc), 69'(exp_bc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        {MemRead, MemWrite, MemSigned, mem_ack} = '0;
        MemSize = '0; ALUResult = '0; WriteData = '0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1 check("reset_mem", {mem_req, mem_we, mem_addr, mem_be, mem_wdata}, '0);
        check("reset_out", {33'b0, ReadData, LoadValid, AddrErr, BusErr, Stall}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        exp_req(1'b1, 32'h100, 4'hF, 32'hDEADBEEF, "st_w");
        access(0, 1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 32'h0, 2, 4, 3, "st_w");
        exp_req(1'b0, 32'h100, 4'b1000, 32'h0, "ld_bs");
        push(1, 69'h0FFFFFF80, "ld_bs data");
        access(1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80112233, 0, 2, 1, "ld_bs");
        exp_req(1'b0, 32'h100, 4'b1100, 32'h0, "ld_hu");
        push(1, 69'h000008011, "ld_hu data");
        access(1, 0, 2'b01, 0, 32'h102, 32'h0, 32'h80112233, 1, 3, 2, "ld_hu");
        exp_req(1'b1, 32'h100, 4'b1100, 32'hABCDABCD, "st_h");
        access(0, 1, 2'b01, 0, 32'h102, 32'h1234ABCD, 32'h0, 0, 2, 1, "st_h");
        exp_req(1'b0, 32'h100, 4'b0010, 32'h0, "ld_bu");
        push(1, 69'h000000022, "ld_bu data");
        access(1, 0, 2'b00, 0, 32'h101, 32'h0, 32'h80112233, 0, 2, 1, "ld_bu");
        exp_req(1'b0, 32'h200, 4'b0011, 32'h0, "ld_hs");
        push(1, 69'h0FFFFF00F, "ld_hs data");
        access(1, 0, 2'b01, 1, 32'h200, 32'h0, 32'h1234F00F, 3, 5, 4, "ld_hs");
        exp_req(1'b1, 32'h200, 4'b1000, 32'h5A5A5A5A, "st_b");
        access(0, 1, 2'b00, 0, 32'h203, 32'h1234565A, 32'h0, 0, 2, 1, "st_b");
        exp_req(1'b0, 32'h204, 4'hF, 32'h0, "ld_w");
        push(1, 69'h0CAFEF00D, "ld_w data");
        access(1, 0, 2'b10, 1, 32'h204, 32'h0, 32'hCAFEF00D, 0, 2, 1, "ld_w");

        mem_ack = 1'b1; mem_rdata = 32'h55555555;
        repeat (2) @(negedge clk);
        mem_ack = 1'b0;
        check("idle_ack_ignored", {37'b0, ReadData}, 69'h0CAFEF00D);

        exp_req(1'b0, 32'h300, 4'hF, 32'h0, "timeout");
        push(3, 69'h0CAFEF00D, "timeout buserr");
        access(1, 0, 2'b10, 0, 32'h300, 32'h0, 32'hFFFFFFFF, -1, 17, 16, "timeout");

        push(2, '0, "misaligned_w");
        access(1, 0, 2'b10, 0, 32'h101, 32'h0, 32'h0, 0, 0, 0, "misaligned_w");
        push(2, '0, "rd_and_wr");
        access(1, 1, 2'b10, 0, 32'h100, 32'h0, 32'h0, 0, 0, 0, "rd_and_wr");
        push(2, '0, "size_11");
        access(1, 0, 2'b11, 0, 32'h100, 32'h0, 32'h0, 0, 0, 0, "size_11");
        push(2, '0, "misaligned_h");
        access(0, 1, 2'b01, 0, 32'h103, 32'h1234, 32'h0, 0, 0, 0, "misaligned_h");
        check("readdata_kept", {37'b0, ReadData}, 69'h0CAFEF00D);

        exp_req(1'b1, 32'h400, 4'hF, 32'h11223344, "rst_busy");
        MemWrite = 1'b1; MemSize = 2'b10; ALUResult = 32'h400; WriteData = 32'h11223344;
        @(negedge clk);
        MemWrite = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("rst_busy_mem", {mem_req, mem_we, mem_addr, mem_be, mem_wdata}, '0);
        check("rst_busy_out", {33'b0, ReadData, LoadValid, AddrErr, BusErr, Stall}, '0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        exp_req(1'b0, 32'h100, 4'b0001, 32'h0, "post_rst");
        push(1, 69'h00000007F, "post_rst data");
        access(1, 0, 2'b00, 1, 32'h100, 32'h0, 32'h0000007F, 0, 2, 1, "post_rst");

        repeat (3) @(negedge clk);
        check("queue_drain", 69'(q.size()), 69'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
